// File: rtl/elevator_car_ctrl.sv
// Four-floor elevator car controller: latches hall/car requests, keeps travelling
// in the current direction while work remains ahead, and times floor and door phases.
module elevator_car_ctrl #(
    parameter int MOVE_CYCLES = 4,
    parameter int DOOR_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] button_up,
    input  logic [2:0] button_down,
    input  logic [3:0] button_in,
    output logic [1:0] position,
    output logic       open,
    output logic       dir,
    output logic       moving,
    output logic [2:0] pend_up,
    output logic [2:0] pend_down,
    output logic [3:0] pend_in
);
    localparam logic [7:0] MOVE_LD = 8'(MOVE_CYCLES);
    localparam logic [7:0] DOOR_LD = 8'(DOOR_CYCLES);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

    state_t     state_q, state_d;
    logic [1:0] pos_q, pos_d;
    logic       dir_q, dir_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] pu_q, pu_d;
    logic [2:0] pd_q, pd_d;
    logic [3:0] pi_q, pi_d;

    logic [3:0] hall_up_f, hall_dn_f, req_f;
    logic [2:0] clr_up, clr_dn, ign_up, ign_dn;
    logic [3:0] clr_in, ign_in;
    logic       go_door;
    logic [1:0] tgt, nxt_pos;

    // Hall requests re-indexed by floor number (no up call at 3, no down call at 0).
    assign hall_up_f = {1'b0, pu_q};
    assign hall_dn_f = {pd_q, 1'b0};
    assign req_f     = pi_q | hall_up_f | hall_dn_f;

    function automatic logic any_beyond(input logic [3:0] req, input logic [1:0] p,
                                        input logic down);
        any_beyond = 1'b0;
        for (int f = 0; f < 4; f++) begin
            if (req[f] && (down ? (f < int'(p)) : (f > int'(p))))
                any_beyond = 1'b1;
        end
    endfunction

    function automatic logic stop_here(input logic [3:0] car, input logic [3:0] hup,
                                       input logic [3:0] hdn, input logic [1:0] p,
                                       input logic down);
        logic hall_dir;
        logic hall_any;
        hall_dir  = down ? hdn[p] : hup[p];
        hall_any  = hup[p] | hdn[p];
        stop_here = car[p] | hall_dir | (hall_any & ~any_beyond(car | hup | hdn, p, down));
    endfunction

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        clr_up  = '0;
        clr_dn  = '0;
        clr_in  = '0;
        ign_up  = '0;
        ign_dn  = '0;
        ign_in  = '0;
        go_door = 1'b0;
        tgt     = pos_q;
        nxt_pos = (state_q == MOVE_DOWN) ? pos_q - 2'd1 : pos_q + 2'd1;

        case (state_q)
            IDLE: begin
                if (req_f[pos_q]) begin
                    go_door = 1'b1;
                end else if (any_beyond(req_f, pos_q, dir_q)) begin
                    state_d = dir_q ? MOVE_DOWN : MOVE_UP;
                    cnt_d   = MOVE_LD;
                end else if (any_beyond(req_f, pos_q, ~dir_q)) begin
                    dir_d   = ~dir_q;
                    state_d = dir_q ? MOVE_UP : MOVE_DOWN;
                    cnt_d   = MOVE_LD;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (cnt_q <= 8'd1) begin
                    pos_d = nxt_pos;
                    tgt   = nxt_pos;
                    if (stop_here(pi_q, hall_up_f, hall_dn_f, nxt_pos, dir_q)) begin
                        go_door = 1'b1;
                    end else if (any_beyond(req_f, nxt_pos, dir_q)) begin
                        cnt_d = MOVE_LD;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DOOR_OPEN: begin
                // The direction already names the hall call served at this stop.
                ign_in[pos_q] = 1'b1;
                if (dir_q && pos_q != 2'd0)
                    ign_dn[pos_q - 2'd1] = 1'b1;
                if (!dir_q && pos_q != 2'd3)
                    ign_up[pos_q] = 1'b1;
                if (cnt_q <= 8'd1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (go_door) begin
            state_d     = DOOR_OPEN;
            cnt_d       = DOOR_LD;
            clr_in[tgt] = 1'b1;
            if (tgt == 2'd0) begin
                clr_up[0] = 1'b1;
                dir_d     = 1'b0;
            end else if (tgt == 2'd3) begin
                clr_dn[2] = 1'b1;
                dir_d     = 1'b1;
            end else if (any_beyond(req_f, tgt, dir_q)) begin
                if (dir_q) clr_dn[tgt - 2'd1] = 1'b1;
                else       clr_up[tgt]        = 1'b1;
            end else begin
                if (dir_q) clr_up[tgt]        = 1'b1;
                else       clr_dn[tgt - 2'd1] = 1'b1;
                dir_d = ~dir_q;
            end
        end

        // A stop that serves a bit wins over a press of that bit on the same edge.
        pi_d = (pi_q | (button_in   & ~ign_in)) & ~clr_in;
        pu_d = (pu_q | (button_up   & ~ign_up)) & ~clr_up;
        pd_d = (pd_q | (button_down & ~ign_dn)) & ~clr_dn;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pos_q   <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            pu_q    <= '0;
            pd_q    <= '0;
            pi_q    <= '0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            pu_q    <= pu_d;
            pd_q    <= pd_d;
            pi_q    <= pi_d;
        end
    end

    assign position  = pos_q;
    assign open      = (state_q == DOOR_OPEN);
    assign moving    = (state_q == MOVE_UP) || (state_q == MOVE_DOWN);
    assign dir       = dir_q;
    assign pend_up   = pu_q;
    assign pend_down = pd_q;
    assign pend_in   = pi_q;
endmodule

// File: tb/tb_elevator_car_ctrl.sv
// Bench for elevator_car_ctrl: per-cycle scoreboard fed by a floor-level reference
// model, plus directed scenarios with hand-derived cycle timings.
module tb_elevator_car_ctrl;
    localparam int MOVE_CYCLES = 4;
    localparam int DOOR_CYCLES = 3;
    localparam int PH_IDLE = 0, PH_TRAVEL = 1, PH_DOOR = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] button_up = '0;
    logic [2:0] button_down = '0;
    logic [3:0] button_in = '0;
    logic [1:0] position;
    logic       open, dir, moving;
    logic [2:0] pend_up, pend_down;
    logic [3:0] pend_in;

    elevator_car_ctrl #(.MOVE_CYCLES(MOVE_CYCLES), .DOOR_CYCLES(DOOR_CYCLES)) dut (
        .clk(clk), .reset(reset), .button_up(button_up), .button_down(button_down),
        .button_in(button_in), .position(position), .open(open), .dir(dir),
        .moving(moving), .pend_up(pend_up), .pend_down(pend_down), .pend_in(pend_in)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [14:0] exp_q[$];

    // Reference model: car floor, travel sense, phase and per-floor call lamps.
    int m_floor = 0;
    bit m_down = 0;
    int m_phase = PH_IDLE;
    int m_timer = 0;
    bit m_car[4], m_hup[4], m_hdn[4];
    bit c_car[4], c_hup[4], c_hdn[4];

    function automatic bit m_wants(int f);
        return m_car[f] | m_hup[f] | m_hdn[f];
    endfunction

    function automatic bit m_beyond(int f, bit down);
        for (int g = 0; g < 4; g++)
            if ((down ? (g < f) : (g > f)) && m_wants(g)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_any();
        for (int g = 0; g < 4; g++)
            if (m_wants(g)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_serve(input int f);
        m_phase = PH_DOOR;
        m_timer = DOOR_CYCLES;
        c_car[f] = 1'b1;
        if (f == 0) begin
            c_hup[0] = 1'b1; m_down = 1'b0;
        end else if (f == 3) begin
            c_hdn[3] = 1'b1; m_down = 1'b1;
        end else if (m_beyond(f, m_down)) begin
            if (m_down) c_hdn[f] = 1'b1; else c_hup[f] = 1'b1;
        end else begin
            if (m_down) c_hup[f] = 1'b1; else c_hdn[f] = 1'b1;
            m_down = !m_down;
        end
    endtask

    task automatic model_step(input bit rst, input logic [2:0] bu, input logic [2:0] bd,
                              input logic [3:0] bi);
        bit in_door, old_down;
        int old_floor;
        bit p_car, p_up, p_dn;
        if (rst) begin
            m_floor = 0; m_down = 0; m_phase = PH_IDLE; m_timer = 0;
            for (int f = 0; f < 4; f++) begin
                m_car[f] = 0; m_hup[f] = 0; m_hdn[f] = 0;
            end
            return;
        end
        for (int f = 0; f < 4; f++) begin
            c_car[f] = 0; c_hup[f] = 0; c_hdn[f] = 0;
        end
        in_door   = (m_phase == PH_DOOR);
        old_floor = m_floor;
        old_down  = m_down;
        case (m_phase)
            PH_IDLE: begin
                if (m_wants(m_floor)) m_serve(m_floor);
                else if (m_beyond(m_floor, m_down)) begin
                    m_phase = PH_TRAVEL; m_timer = MOVE_CYCLES;
                end else if (m_beyond(m_floor, !m_down)) begin
                    m_down = !m_down; m_phase = PH_TRAVEL; m_timer = MOVE_CYCLES;
                end
            end
            PH_TRAVEL: begin
                m_timer--;
                if (m_timer == 0) begin
                    m_floor = m_down ? m_floor - 1 : m_floor + 1;
                    if (m_car[m_floor] || (m_down ? m_hdn[m_floor] : m_hup[m_floor]) ||
                        (!m_beyond(m_floor, m_down) && (m_hup[m_floor] || m_hdn[m_floor])))
                        m_serve(m_floor);
                    else if (m_any() && m_beyond(m_floor, m_down))
                        m_timer = MOVE_CYCLES;
                    else begin
                        m_phase = PH_IDLE; m_timer = 0;
                    end
                end
            end
            default: begin
                m_timer--;
                if (m_timer == 0) m_phase = PH_IDLE;
            end
        endcase
        for (int f = 0; f < 4; f++) begin
            p_car = bi[f];
            p_up  = 1'b0;
            p_dn  = 1'b0;
            if (f < 3) p_up = bu[f];
            if (f > 0) p_dn = bd[f-1];
            if (in_door && f == old_floor) begin
                p_car = 1'b0;
                if (old_down) p_dn = 1'b0; else p_up = 1'b0;
            end
            m_car[f] = (m_car[f] | p_car) & !c_car[f];
            m_hup[f] = (m_hup[f] | p_up) & !c_hup[f];
            m_hdn[f] = (m_hdn[f] | p_dn) & !c_hdn[f];
        end
    endtask

    function automatic logic [14:0] model_outputs();
        logic [2:0] pu, pd;
        logic [3:0] pi;
        for (int i = 0; i < 3; i++) begin
            pu[i] = m_hup[i];
            pd[i] = m_hdn[i+1];
        end
        for (int i = 0; i < 4; i++) pi[i] = m_car[i];
        return {2'(m_floor), m_phase == PH_DOOR, m_down, m_phase == PH_TRAVEL, pu, pd, pi};
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            model_step(reset, button_up, button_down, button_in);
            exp_q.push_back(model_outputs());
        end
    end

    initial begin
        logic [14:0] exp_v, got_v;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                got_v = {position, open, dir, moving, pend_up, pend_down, pend_in};
                checks++;
                if (got_v !== exp_v) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t {pos,open,dir,mov,pu,pd,pi} got=%b expected=%b",
                             $time, got_v, exp_v);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp_v);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_open(input string name, input int max_cycles);
        int n;
        n = 0;
        while (!open && n < max_cycles) begin
            tick();
            n++;
        end
        chk({name, "_open_timeout"}, 8'(open), 8'd1);
    endtask

    initial begin
        repeat (2) tick();
        reset = 1'b0;
        chk("rst_position", 8'(position), 8'd0);
        chk("rst_open", 8'(open), 8'd0);
        chk("rst_moving", 8'(moving), 8'd0);
        chk("rst_pend_in", 8'(pend_in), 8'd0);

        // Car call to floor 2 from idle at floor 0.
        button_in = 4'b0100; tick(); button_in = '0;
        tick();
        chk("r26_moving_c2", 8'(moving), 8'd1);
        repeat (4) tick();
        chk("r26_pos_c6", 8'(position), 8'd1);
        repeat (4) tick();
        chk("r26_pos_c10", 8'(position), 8'd2);
        chk("r26_open_c10", 8'(open), 8'd1);
        chk("r26_pend_in2_c10", 8'(pend_in[2]), 8'd0);
        repeat (3) tick();
        chk("r26_open_c13", 8'(open), 8'd0);
        chk("r26_moving_c13", 8'(moving), 8'd0);

        // Reset mid-travel at floor 1; a press during the reset cycle is dropped.
        do_reset();
        button_in = 4'b1000; tick(); button_in = '0;
        repeat (6) tick();
        chk("r30_pos_before", 8'(position), 8'd1);
        chk("r30_moving_before", 8'(moving), 8'd1);
        reset = 1'b1; button_up = 3'b100; tick(); reset = 1'b0; button_up = '0;
        chk("r30_pos", 8'(position), 8'd0);
        chk("r30_moving", 8'(moving), 8'd0);
        chk("r30_open", 8'(open), 8'd0);
        chk("r30_dir", 8'(dir), 8'd0);
        chk("r30_pend", 8'({pend_up, pend_down, pend_in}), 8'd0);

        // Hall up at the car's own floor 0.
        button_up = 3'b001; tick(); button_up = '0;
        tick();
        chk("r27_open_c2", 8'(open), 8'd1);
        chk("r27_pend_up0_c2", 8'(pend_up[0]), 8'd0);
        chk("r27_pos_c2", 8'(position), 8'd0);
        repeat (2) tick();
        chk("r27_open_c4", 8'(open), 8'd1);
        tick();
        chk("r27_open_c5", 8'(open), 8'd0);

        // Only a down call at floor 2.
        do_reset();
        button_down = 3'b010; tick(); button_down = '0;
        wait_open("r29", 40);
        chk("r29_pos", 8'(position), 8'd2);
        chk("r29_dir", 8'(dir), 8'd1);
        chk("r29_pend_down1", 8'(pend_down[1]), 8'd0);

        // Up trip to 3 with up call at 1 and down call at 1 on the way.
        do_reset();
        button_in = 4'b1000; tick(); button_in = '0;
        button_up = 3'b010; button_down = 3'b001; tick(); button_up = '0; button_down = '0;
        wait_open("r28", 40);
        chk("r28_pos", 8'(position), 8'd1);
        chk("r28_pend_up1", 8'(pend_up[1]), 8'd0);
        chk("r28_pend_down0", 8'(pend_down[0]), 8'd1);
        repeat (60) tick();

        // Presses at the open door's floor and elsewhere.
        do_reset();
        button_in = 4'b1010; tick(); button_in = '0;
        wait_open("r31", 40);
        chk("r31_pos", 8'(position), 8'd1);
        button_in = 4'b0010; button_up = 3'b001; tick(); button_in = '0; button_up = '0;
        chk("r31_pend_in1", 8'(pend_in[1]), 8'd0);
        chk("r31_pend_up0", 8'(pend_up[0]), 8'd1);
        chk("r31_open_2nd", 8'(open), 8'd1);
        tick();
        chk("r31_open_3rd", 8'(open), 8'd1);
        tick();
        chk("r31_open_after", 8'(open), 8'd0);

        // Random traffic with occasional resets, scoreboard only.
        for (int i = 0; i < 4000; i++) begin
            for (int b = 0; b < 3; b++) begin
                button_up[b]   = ($urandom_range(0, 15) == 0);
                button_down[b] = ($urandom_range(0, 15) == 0);
            end
            for (int b = 0; b < 4; b++) button_in[b] = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 399) == 0);
            tick();
        end
        reset = 1'b0; button_up = '0; button_down = '0; button_in = '0;
        repeat (120) tick();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/elevator_car_ctrl.md
ELEVATOR_CAR_CTRL -- requirements
Module: elevator_car_ctrl

Interface
REQ-001 SHALL have parameter MOVE_CYCLES, default 4: clock cycles of travel per floor (legal 1..255).
REQ-002 SHALL have parameter DOOR_CYCLES, default 3: clock cycles the door stays open per stop (legal 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port button_up  input  3  hall-up presses, bit i = floor i (floors 0..2), level, one cycle suffices.
REQ-006 SHALL have port button_down  input  3  hall-down presses, bit i = floor i+1 (floors 1..3).
REQ-007 SHALL have port button_in  input  4  car-panel presses, bit i = floor i.
REQ-008 SHALL have port position  output  2  current floor 0..3.
REQ-009 SHALL have port open  output  1  door open; high exactly in DOOR_OPEN.
REQ-010 SHALL have port dir  output  1  travel direction, 0 = up, 1 = down.
REQ-011 SHALL have port moving  output  1  high in MOVE_UP or MOVE_DOWN.
REQ-012 SHALL have ports pend_up 3, pend_down 3, pend_in 4 (outputs): registered pending requests, same bit mapping as inputs (lamp drive).

Function
REQ-013 SHALL set a pending bit on the edge after its button is sampled high; set is level-or, repeated presses idempotent.
REQ-014 SHALL implement states IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, one-hot or encoded.
REQ-015 SHALL define above/below = any pending bit (any of the three vectors) at a floor strictly above/below position.
REQ-016 IDLE: if pend_in[pos], or any hall bit at pos, is set -> DOOR_OPEN next edge; else if requests in dir exist -> move in dir; else if requests opposite exist -> flip dir, move; else stay IDLE.
REQ-017 MOVE: travel counter loads MOVE_CYCLES on entry; on the edge it reaches expiry, position increments (MOVE_UP) or decrements (MOVE_DOWN) and the stop decision is made for the new floor on that same edge.
REQ-018 Stop condition at new floor p: pend_in[p], or hall bit at p matching dir, or no requests beyond p in dir and any hall bit at p; stop -> DOOR_OPEN, else no requests anywhere -> IDLE, else counter reloads and motion continues.
REQ-019 On entry to DOOR_OPEN SHALL clear pend_in[p] and the hall bit at p matching dir; if no requests beyond p in dir, SHALL instead clear the opposite hall bit at p and flip dir.
REQ-020 Floor 0 has no down bit, floor 3 no up bit; at these floors the existing hall bit is the one served and dir becomes up at 0, down at 3.
REQ-021 DOOR_OPEN: door counter loads DOOR_CYCLES; open high for exactly DOOR_CYCLES cycles, then IDLE.
REQ-022 During DOOR_OPEN, presses of pend_in[p] and the served hall bit at p SHALL be ignored; timer not restarted.
REQ-023 position SHALL never leave 0..3; motion only starts when a request exists beyond pos in that direction.
REQ-024 Pending bits at other floors SHALL accept presses in every state.

Reset
REQ-025 On reset high at an edge: state IDLE, position 0, dir 0, open 0, moving 0, all pend bits 0, counters 0, regardless of state (including mid-move or door open); presses in the reset cycle are discarded.

Verification
REQ-026 pos 0 IDLE, button_in=4'b0100 one cycle at c0 -> moving at c2, position 1 at c6, position 2 and open at c10, pend_in[2] 0 at c10, open low and IDLE at c13.
REQ-027 pos 0 IDLE, button_up[0] at c0 -> open at c2 through c4, pend_up[0] cleared at c2, position stays 0.
REQ-028 car moving up to floor 3 (button_in[3]), button_up[1] and button_down[0] pressed before floor 1 -> stop at 1 clears pend_up[1] only; pend_down[0] served on way down after floor 3.
REQ-029 pos 0, only button_down[1] (floor 2) -> car travels up, stops at floor 2, dir becomes 1, pend_down[1] cleared.
REQ-030 reset asserted one cycle mid-MOVE_UP at position 1 -> next cycle position 0, IDLE, all outputs 0, pending cleared.
REQ-031 door open at floor 1 dir up, button_in[1] and button_up[0] pressed -> pend_in[1] stays 0, pend_up[0] sets, open lasts exactly DOOR_CYCLES.
